// File: rtl/gray4_seq_monitor.sv
// Gray-code step monitor: converts a 4-bit gray count to binary and flags illegal steps.
// Define GRAY4MON_WCNT_EN to build the 8-bit saturating wrap counter; otherwise WCNT is tied to 0.
module gray4_seq_monitor (
  input  logic       CLK,
  input  logic       CDN,
  input  logic       G0,
  input  logic       G1,
  input  logic       G2,
  input  logic       G3,
  input  logic       SMP,
  input  logic       SKIP,
  input  logic       CLR,
  output logic       B0,
  output logic       B1,
  output logic       B2,
  output logic       B3,
  output logic       STEP,
  output logic       WRAP,
  output logic       ERR,
  output logic [7:0] WCNT
);

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic [W-1:0] w_gray;
  logic [W-1:0] w_bin;
  logic [W-1:0] w_prev_inc;
  logic         w_chk;
  logic         w_step;
  logic         w_wrap;
  logic         w_bad;
  logic         w_err_nxt;

  logic [W-1:0] r_bin;
  logic         r_primed;
  logic         r_step;
  logic         r_wrap;
  logic         r_err;

  assign w_gray = {G3, G2, G1, G0};

  // Prefix-XOR from the MSB down gives the binary value.
  always_comb begin
    w_bin      = '0;
    w_bin[W-1] = w_gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ w_gray[i];
    end
  end

  assign w_prev_inc = W'(r_bin + W'(1));
  assign w_chk      = SMP & r_primed & ~SKIP;
  assign w_step     = w_chk & (w_bin == w_prev_inc);
  assign w_wrap     = w_step & (r_bin == {W{1'b1}});
  assign w_bad      = w_chk & (w_bin != w_prev_inc) & (w_bin != r_bin);

  always_comb begin
    w_err_nxt = r_err | w_bad;
    if (CLR) begin
      w_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_bin    <= '0;
      r_primed <= 1'b0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_step <= w_step;
      r_wrap <= w_wrap;
      r_err  <= w_err_nxt;
      if (SMP) begin
        r_bin    <= w_bin;
        r_primed <= 1'b1;
      end
    end
  end

`ifdef GRAY4MON_WCNT_EN
  logic [CW-1:0] r_wcnt;
  logic [CW-1:0] w_wcnt_nxt;

  // Saturating wrap count; CLR wins over a same-edge increment.
  always_comb begin
    w_wcnt_nxt = r_wcnt;
    if (CLR) begin
      w_wcnt_nxt = '0;
    end else if (w_wrap && (r_wcnt != {CW{1'b1}})) begin
      w_wcnt_nxt = CW'(r_wcnt + CW'(1));
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= w_wcnt_nxt;
    end
  end

  assign WCNT = r_wcnt;
`else
  assign WCNT = CW'(0);
`endif

  assign {B3, B2, B1, B0} = r_bin;
  assign STEP = r_step;
  assign WRAP = r_wrap;
  assign ERR  = r_err;

endmodule
